input_decimator: RTL
====================

# input_decimator

Downstream stage of the data acquisition front end: selects one of the three sample streams (simulated, high-speed ADC channel A/B, ADC 2308), converts it to signed 32-bit, and block-averages 2^k consecutive valid samples. The result is a single decimated stream with a one-cycle valid pulse, consumed by the lock-in processing chain. All inputs are already synchronous to `clk`.

## Interface
- `MAX_LOG2_DEC`, 10: largest supported decimation exponent; accumulator width is 32+MAX_LOG2_DEC.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run; low flushes and idles the block.
- `sel_source` in 2: 0 sim, 1 HS ADC ch A, 2 HS ADC ch B, 3 ADC 2308.
- `log2_dec` in 4: decimation exponent k; block length is 2^k; values > MAX_LOG2_DEC are clamped.
- `sim_data` in 32: signed simulated sample. `sim_valid` in 1.
- `adc_a`, `adc_b` in 14 each: HS ADC samples, offset binary. `adc_valid` in 1.
- `adc_2308` in 32: unsigned, 12 significant LSBs. `adc_2308_valid` in 1.
- `data_out` out 32: signed block average.
- `data_out_valid` out 1: one-cycle pulse per finished block.
- `block_count` out 32: number of blocks emitted since the last enable rise; wraps.
- `busy` out 1: high in ACCUM.

## Operation
- FSM states:
  - IDLE: entered on reset or `enable`=0.
  - ACCUM: entered from IDLE on the first cycle with `enable`=1. On entry, `sel_source` and clamped `log2_dec` are latched, and accumulator, sample counter and `block_count` are cleared.
  - Any cycle with `enable`=0 returns the FSM to IDLE.
- Configuration changes made during ACCUM are ignored until the next IDLE→ACCUM transition.
- Input conversion, stage S1 (registered):
  - sim: passed through unchanged.
  - HS ADC: MSB inverted, then sign-extended from 14 bits (0x0000→-8192, 0x2000→0, 0x3FFF→8191).
  - 2308: bits [11:0] zero-extended.
- The valid signal used is the one belonging to the latched source. Valids of unselected sources are ignored.
- Stage S2, accumulate:
  - On an S1-valid cycle, `acc <= acc + sample` (42-bit signed) and `cnt` increments.
  - When `cnt == 2^k-1`, `data_out <= (acc + sample) >>> k`, truncated to 32 bits. `data_out_valid` pulses, `acc` and `cnt` clear, and `block_count` increments.
- k=0: every valid sample is output unchanged.
- Overflow is impossible by construction: 2^10 × 32-bit fits in 42 bits, and the average always fits in 32 bits.
- `enable` falling mid-block discards the partial sum and S1 contents. No output is produced for that block. `data_out` holds its last value.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `block_count`=0, `busy`=0, FSM=IDLE, acc=0, cnt=0.
- Latency: the final sample of a block, sampled valid on edge n, produces `data_out_valid`=1 during the cycle after edge n+1, i.e. 2 cycles.
- Throughput: one sample per clock, including valid every cycle with k=0.
- The first sample accepted is the one whose valid is sampled on the edge after `enable` rises. A valid on the same edge that performs IDLE→ACCUM is dropped.
- `data_out_valid` is never high for two consecutive cycles unless k=0.
- Asynchronous `reset` mid-block clears everything immediately. No output is produced for the interrupted block.

## Configuration
- `INPUT_DECIM_ROUND_EN`:
  - Defined: for k>0 the output is `(sum + 2^(k-1)) >>> k`, i.e. round half toward +inf.
  - Undefined: plain arithmetic shift, floor toward -inf.
  - k=0 output is identical in both cases.

## Test plan
- sel=1, k=2, `adc_a`=0x2000+{1,2,3,4} with valid every cycle → one pulse, `data_out`=2 (3 with ROUND_EN), 2 cycles after the 4th sample; `block_count`=1.
- sel=0, k=0, `sim_data`=-5,7,0x7FFFFFFF on consecutive cycles → three consecutive pulses carrying -5, 7, 0x7FFFFFFF.
- sel=2, k=10, `adc_b`=0x0000 for 1024 samples with sparse valid (1 in 3 cycles) → exactly one pulse, `data_out`=-8192.
- sel=3, k=3, 5 samples of 0xABC then `enable` low, then 8 samples of 100 after `enable` re-rises → only one output, 100; `block_count`=1.
- k=15 requested, sel=0, `sim_data`=1 → first pulse after 1024 samples, value 1 (clamp).
- Assert `reset` mid-block with k=2 after 3 samples → all outputs 0 immediately, `busy`=0, and no pulse is produced.

Source files
------------

// File: rtl/input_decimator.sv
// -----------------------------------------------------------------------------
// input_decimator
//
// Picks one of three sample streams (simulated, high-speed ADC channel A/B,
// ADC 2308) and converts it to signed 32 bits. It then block-averages 2^k
// consecutive valid samples and emits one decimated sample with a one-cycle
// valid pulse.
//
// Pipeline:
//   S1 registers the converted sample of the latched source.
//   S2 accumulates it and produces the average.
//   The last sample of a block, sampled on edge n, appears on data_out with
//   data_out_valid during the cycle after edge n+1.
//
// Optional feature macro:
//   INPUT_DECIM_ROUND_EN
//     Defined: for k>0 the average is (sum + 2^(k-1)) >>> k, which rounds
//       half toward +inf.
//     Undefined: plain arithmetic shift, which floors toward -inf.
//
// Ports:
//   clk             single clock
//   reset           asynchronous, active-high
//   enable          run; low flushes and idles the block
//   sel_source      0 sim, 1 HS ADC A, 2 HS ADC B, 3 ADC 2308
//   log2_dec        decimation exponent k, clamped to MAX_LOG2_DEC
//   sim_data/valid  signed 32-bit simulated samples
//   adc_a/adc_b     14-bit offset-binary HS ADC samples, shared adc_valid
//   adc_2308/valid  unsigned, 12 significant LSBs
//   data_out        signed block average
//   data_out_valid  one-cycle pulse per finished block
//   block_count     blocks emitted since the last enable rise (wraps)
//   busy            high while accumulating
// -----------------------------------------------------------------------------
module input_decimator #(
  parameter int MAX_LOG2_DEC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  sel_source,
  input  logic [3:0]  log2_dec,
  input  logic [31:0] sim_data,
  input  logic        sim_valid,
  input  logic [13:0] adc_a,
  input  logic [13:0] adc_b,
  input  logic        adc_valid,
  input  logic [31:0] adc_2308,
  input  logic        adc_2308_valid,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic [31:0] block_count,
  output logic        busy
);

  localparam int ACC_W = 32 + MAX_LOG2_DEC;
  localparam int CNT_W = (MAX_LOG2_DEC > 0) ? MAX_LOG2_DEC : 1;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_e;

  state_e                   state_q;
  logic [1:0]               sel_q;
  logic [3:0]               k_q;
  logic                     s1_valid_q;
  logic signed [31:0]       s1_data_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [31:0]              data_out_q;
  logic                     data_out_valid_q;
  logic [31:0]              block_count_q;
  logic                     busy_q;

  logic [3:0]               k_clamped;
  logic                     src_valid;
  logic signed [31:0]       src_sample;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  sum_rnd;
  logic signed [ACC_W-1:0]  avg_full;
  logic [31:0]              data_out_d;
  logic [CNT_W:0]           blk_last_idx;
  logic                     blk_last;
  logic                     unused_bits;

  assign k_clamped = (log2_dec > 4'(MAX_LOG2_DEC)) ? 4'(MAX_LOG2_DEC) : log2_dec;

  // Source mux and conversion. It uses the latched selection, so valids of
  // unselected sources never reach S1.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    src_valid  = 1'b0;
    src_sample = '0;
    case (sel_q)
      2'd0: begin
        src_valid  = sim_valid;
        src_sample = sim_data;
      end
      2'd1: begin
        // Offset binary to two's complement: invert the MSB, then sign-extend.
        src_valid  = adc_valid;
        src_sample = {{18{~adc_a[13]}}, ~adc_a[13], adc_a[12:0]};
      end
      2'd2: begin
        src_valid  = adc_valid;
        src_sample = {{18{~adc_b[13]}}, ~adc_b[13], adc_b[12:0]};
      end
      default: begin
        src_valid  = adc_2308_valid;
        src_sample = {20'd0, adc_2308[11:0]};
      end
    endcase
  end

  // S2 datapath. The block's final sum includes the sample currently in S1.
  always_comb begin
    sum_d = acc_q + {{MAX_LOG2_DEC{s1_data_q[31]}}, s1_data_q};
`ifdef INPUT_DECIM_ROUND_EN
    if (k_q == 4'd0) sum_rnd = sum_d;
    else             sum_rnd = sum_d + (ACC_W'(1) << (k_q - 4'd1));
`else
    sum_rnd = sum_d;
`endif
    avg_full   = sum_rnd >>> k_q;
    data_out_d = avg_full[31:0];
  end

  assign blk_last_idx = ((CNT_W + 1)'(1) << k_q) - (CNT_W + 1)'(1);
  assign blk_last     = ({1'b0, cnt_q} == blk_last_idx);

  // Upper 2308 bits are not significant. The average always fits in 32 bits.
  assign unused_bits = ^{adc_2308[31:12], avg_full[ACC_W-1:32]};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      sel_q            <= 2'd0;
      k_q              <= 4'd0;
      s1_valid_q       <= 1'b0;
      s1_data_q        <= '0;
      acc_q            <= '0;
      cnt_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      block_count_q    <= '0;
      busy_q           <= 1'b0;
    end else if (!enable) begin
      // Flush: the partial block and S1 are discarded. data_out keeps its
      // last value.
      state_q          <= S_IDLE;
      s1_valid_q       <= 1'b0;
      acc_q            <= '0;
      cnt_q            <= '0;
      data_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Configuration is frozen here. A valid on this edge is dropped.
          state_q          <= S_ACCUM;
          busy_q           <= 1'b1;
          sel_q            <= sel_source;
          k_q              <= k_clamped;
          acc_q            <= '0;
          cnt_q            <= '0;
          block_count_q    <= '0;
          s1_valid_q       <= 1'b0;
          data_out_valid_q <= 1'b0;
        end
        default: begin
          s1_valid_q       <= src_valid;
          s1_data_q        <= src_sample;
          data_out_valid_q <= 1'b0;
          if (s1_valid_q) begin
            if (blk_last) begin
              data_out_q       <= data_out_d;
              data_out_valid_q <= 1'b1;
              acc_q            <= '0;
              cnt_q            <= '0;
              block_count_q    <= block_count_q + 32'd1;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign block_count    = block_count_q;
  assign busy           = busy_q;

endmodule
